// File: rtl/stack_cpu_controller.sv
// Multi-cycle control FSM for the stack processor: sequences fetch/decode/execute
// and tracks stack occupancy so over/underflow halts the machine before the stack is touched.
module stack_cpu_controller #(
   parameter int STACK_DEPTH = 32,
   parameter int DEPTH_INIT  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [2:0] opcode,
   input  logic       tos_zero,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       iord,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       stack_push,
   output logic       stack_pop,
   output logic       stack_tos,
   output logic       push_src,
   output logic       a_load,
   output logic       b_load,
   output logic [1:0] alu_op,
   output logic [5:0] depth,
   output logic       halted,
   output logic       err_ovf,
   output logic       err_unf
);

   typedef enum logic [3:0] {
      S_IDLE, S_IF, S_ID, S_POP1, S_POP2, S_LATA, S_EXE,
      S_WB, S_MRD, S_PSH, S_MWR, S_TOS, S_JZ_CHK, S_HALT
   } state_t;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_NOT  = 3'b011;
   localparam logic [2:0] OP_PUSH = 3'b100;
   localparam logic [2:0] OP_POP  = 3'b101;
   localparam logic [2:0] OP_JMP  = 3'b110;
   localparam logic [2:0] OP_JZ   = 3'b111;

   localparam logic [5:0] DEPTH_MAX = 6'(STACK_DEPTH);
   localparam logic [5:0] DEPTH_RST = 6'(DEPTH_INIT);

   state_t     state;
   state_t     state_next;
   logic [5:0] need;
   logic       is_binary;
   logic       underflow;
   logic       overflow;

   // Minimum occupancy each opcode must find on the stack before it may proceed.
   always_comb begin
      need = 6'd0;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND: need = 6'd2;
         OP_NOT, OP_POP, OP_JZ:  need = 6'd1;
         default:                need = 6'd0;
      endcase
   end

   assign is_binary = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND);
   assign underflow = (depth < need);
   assign overflow  = (opcode == OP_PUSH) && (depth == DEPTH_MAX);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Occupancy follows the push/pop strobes; error flags are sticky until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         depth   <= DEPTH_RST;
         err_unf <= 1'b0;
         err_ovf <= 1'b0;
      end else begin
         if (state == S_ID && underflow) err_unf <= 1'b1;
         if (state == S_ID && !underflow && overflow) err_ovf <= 1'b1;
         if (stack_pop && depth != 6'd0)              depth <= depth - 6'd1;
         else if (stack_push && depth < DEPTH_MAX)    depth <= depth + 6'd1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (run) state_next = S_IF;
         S_IF:     state_next = S_ID;
         S_ID: begin
            if (underflow || overflow) state_next = S_HALT;
            else begin
               case (opcode)
                  OP_JMP:  state_next = S_IF;
                  OP_PUSH: state_next = S_MRD;
                  OP_JZ:   state_next = S_TOS;
                  default: state_next = S_POP1;
               endcase
            end
         end
         S_POP1: begin
            if (is_binary)              state_next = S_POP2;
            else if (opcode == OP_NOT)  state_next = S_LATA;
            else                        state_next = S_MWR;
         end
         S_POP2:   state_next = S_EXE;
         S_LATA:   state_next = S_EXE;
         S_EXE:    state_next = S_WB;
         S_WB:     state_next = S_IF;
         S_MRD:    state_next = S_PSH;
         S_PSH:    state_next = S_IF;
         S_MWR:    state_next = S_IF;
         S_TOS:    state_next = S_JZ_CHK;
         S_JZ_CHK: state_next = S_IF;
         S_HALT:   state_next = S_HALT;
         default:  state_next = S_IDLE;
      endcase
   end

   always_comb begin
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      stack_push = 1'b0;
      stack_pop  = 1'b0;
      stack_tos  = 1'b0;
      push_src   = 1'b0;
      a_load     = 1'b0;
      b_load     = 1'b0;
      alu_op     = 2'b00;
      halted     = 1'b0;
      case (state)
         S_IF: begin
            mem_read = 1'b1;
            ir_write = 1'b1;
            pc_inc   = 1'b1;
         end
         S_ID:     pc_load = (opcode == OP_JMP);
         S_POP1:   stack_pop = 1'b1;
         S_POP2: begin
            a_load    = 1'b1;
            stack_pop = 1'b1;
         end
         S_LATA:   a_load = 1'b1;
         S_EXE: begin
            b_load = is_binary;
            alu_op = opcode[1:0];
         end
         S_WB:     stack_push = 1'b1;
         S_MRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         S_PSH: begin
            stack_push = 1'b1;
            push_src   = 1'b1;
         end
         S_MWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         S_TOS:    stack_tos = 1'b1;
         S_JZ_CHK: pc_load = tos_zero;
         S_HALT:   halted = 1'b1;
         default:  ;
      endcase
   end

endmodule

// File: tb/tb_stack_cpu_controller.sv
// Self-checking bench for stack_cpu_controller: directed table, corner sequences and
// a random opcode stream checked against an instruction-level reference model.
module tb_stack_cpu_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic [2:0] opcode;
   logic       tos_zero;
   logic       ir_write, mem_read, mem_write, iord, pc_inc, pc_load;
   logic       stack_push, stack_pop, stack_tos, push_src, a_load, b_load;
   logic [1:0] alu_op;
   logic [5:0] depth;
   logic       halted, err_ovf, err_unf;

   int compared   = 0;
   int mismatched = 0;

   int cyc, n_pop, n_push, n_tos, n_pcl, n_mrd, n_mwr, n_aload, n_bload;
   int alu_seen, src_seen, prev_alu;
   int m_depth;

   typedef struct {
      logic [2:0] op;
      logic       tz;
      int         cycles;
      int         depth_after;
      int         pc_loads;
      logic       halt;
   } vec_t;

   vec_t vecs[11];

   stack_cpu_controller #(.STACK_DEPTH(32), .DEPTH_INIT(2)) dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .tos_zero(tos_zero),
      .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
      .pc_inc(pc_inc), .pc_load(pc_load), .stack_push(stack_push), .stack_pop(stack_pop),
      .stack_tos(stack_tos), .push_src(push_src), .a_load(a_load), .b_load(b_load),
      .alu_op(alu_op), .depth(depth), .halted(halted), .err_ovf(err_ovf), .err_unf(err_unf)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic int allStrobes();
      return int'({ir_write, mem_read, mem_write, iord, pc_inc, pc_load, stack_push,
                   stack_pop, stack_tos, push_src, a_load, b_load, alu_op});
   endfunction

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1; run = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      m_depth = 2;
   endtask

   task automatic startRun();
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      checkOutput("enter_if", int'(ir_write), 1);
   endtask

   // Runs one instruction from an observed IF cycle until the next IF or HALT.
   task automatic applyStimulus(input logic [2:0] op, input logic tz);
      opcode = op; tos_zero = tz;
      cyc = 0; n_pop = 0; n_push = 0; n_tos = 0; n_pcl = 0; n_mrd = 0; n_mwr = 0;
      n_aload = 0; n_bload = 0; alu_seen = -1; src_seen = -1; prev_alu = 0;
      for (int k = 0; k < 12; k++) begin
         checkOutput("stack_onehot", int'($countones({stack_push, stack_pop, stack_tos}) <= 1), 1);
         checkOutput("mem_exclusive", int'(mem_read && mem_write), 0);
         n_pop += int'(stack_pop); n_push += int'(stack_push); n_tos += int'(stack_tos);
         n_pcl += int'(pc_load); n_mrd += int'(mem_read); n_mwr += int'(mem_write);
         n_aload += int'(a_load); n_bload += int'(b_load);
         if (stack_push) begin
            src_seen = int'(push_src);
            if (!push_src) alu_seen = prev_alu;
         end
         prev_alu = int'(alu_op);
         cyc++;
         @(negedge clk);
         if (ir_write || halted) break;
      end
   endtask

   // Instruction-level reference: occupancy rules and per-opcode strobe totals.
   task automatic checkModel(input logic [2:0] op, input logic tz);
      int need, lat, pops, pushes, delta;
      logic f_unf, f_ovf;
      need  = (op <= 3'd2) ? 2 : ((op == 3'd3 || op == 3'd5 || op == 3'd7) ? 1 : 0);
      f_unf = (m_depth < need);
      f_ovf = (op == 3'd4) && (m_depth == 32);
      applyStimulus(op, tz);
      if (f_unf || f_ovf) begin
         checkOutput("fault_cycles", cyc, 2);
         checkOutput("fault_halted", int'(halted), 1);
         checkOutput("fault_err_unf", int'(err_unf), int'(f_unf));
         checkOutput("fault_err_ovf", int'(err_ovf), int'(f_ovf));
         checkOutput("fault_stack_ops", n_pop + n_push + n_tos, 0);
         checkOutput("fault_depth", int'(depth), m_depth);
         return;
      end
      case (op)
         3'd0, 3'd1, 3'd2: begin lat = 6; pops = 2; pushes = 1; delta = -1; end
         3'd3:             begin lat = 6; pops = 1; pushes = 1; delta = 0;  end
         3'd4:             begin lat = 4; pops = 0; pushes = 1; delta = 1;  end
         3'd5:             begin lat = 4; pops = 1; pushes = 0; delta = -1; end
         3'd6:             begin lat = 2; pops = 0; pushes = 0; delta = 0;  end
         default:          begin lat = 4; pops = 0; pushes = 0; delta = 0;  end
      endcase
      m_depth += delta;
      checkOutput("latency", cyc, lat);
      checkOutput("pops", n_pop, pops);
      checkOutput("pushes", n_push, pushes);
      checkOutput("tos_reads", n_tos, (op == 3'd7) ? 1 : 0);
      checkOutput("pc_loads", n_pcl, (op == 3'd6) ? 1 : ((op == 3'd7) ? int'(tz) : 0));
      checkOutput("mem_reads", n_mrd, (op == 3'd4) ? 2 : 1);
      checkOutput("mem_writes", n_mwr, (op == 3'd5) ? 1 : 0);
      checkOutput("a_loads", n_aload, (op <= 3'd3) ? 1 : 0);
      checkOutput("b_loads", n_bload, (op <= 3'd2) ? 1 : 0);
      checkOutput("depth", int'(depth), m_depth);
      checkOutput("halted", int'(halted), 0);
      if (op <= 3'd3) begin
         checkOutput("alu_op", alu_seen, int'(op));
         checkOutput("push_src_alu", src_seen, 0);
      end
      if (op == 3'd4) checkOutput("push_src_mem", src_seen, 1);
   endtask

   initial begin
      logic [6:0] exp_seq [6];
      logic [2:0] rop;

      vecs[0]  = '{3'd0, 1'b0, 6, 1, 0, 1'b0};
      vecs[1]  = '{3'd7, 1'b1, 4, 1, 1, 1'b0};
      vecs[2]  = '{3'd7, 1'b0, 4, 1, 0, 1'b0};
      vecs[3]  = '{3'd4, 1'b0, 4, 2, 0, 1'b0};
      vecs[4]  = '{3'd4, 1'b0, 4, 3, 0, 1'b0};
      vecs[5]  = '{3'd1, 1'b0, 6, 2, 0, 1'b0};
      vecs[6]  = '{3'd3, 1'b0, 6, 2, 0, 1'b0};
      vecs[7]  = '{3'd6, 1'b0, 2, 2, 1, 1'b0};
      vecs[8]  = '{3'd2, 1'b0, 6, 1, 0, 1'b0};
      vecs[9]  = '{3'd5, 1'b0, 4, 0, 0, 1'b0};
      vecs[10] = '{3'd7, 1'b1, 2, 0, 0, 1'b1};

      // {ir_write, mem_read, pc_inc, stack_pop, a_load, b_load, stack_push}
      exp_seq[0] = 7'b1110000;
      exp_seq[1] = 7'b0000000;
      exp_seq[2] = 7'b0001000;
      exp_seq[3] = 7'b0001100;
      exp_seq[4] = 7'b0000010;
      exp_seq[5] = 7'b0000001;

      rst = 1'b1; run = 1'b0; opcode = 3'd0; tos_zero = 1'b0;
      doReset();
      checkOutput("reset_strobes", allStrobes(), 0);
      checkOutput("reset_depth", int'(depth), 2);
      checkOutput("reset_flags", int'({halted, err_ovf, err_unf}), 0);
      @(negedge clk);
      checkOutput("idle_holds", allStrobes(), 0);

      $display("[TB] directed vector table");
      startRun();
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op, vecs[i].tz);
         checkOutput($sformatf("vec%0d_cycles", i), cyc, vecs[i].cycles);
         checkOutput($sformatf("vec%0d_depth", i), int'(depth), vecs[i].depth_after);
         checkOutput($sformatf("vec%0d_pc_load", i), n_pcl, vecs[i].pc_loads);
         checkOutput($sformatf("vec%0d_halted", i), int'(halted), int'(vecs[i].halt));
      end
      checkOutput("table_err_unf", int'(err_unf), 1);

      $display("[TB] reset during POP2");
      doReset();
      startRun();
      opcode = 3'd0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      checkOutput("pop2_reached", int'({stack_pop, a_load}), 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midrst_strobes", allStrobes(), 0);
      checkOutput("midrst_depth", int'(depth), 2);
      checkOutput("midrst_flags", int'({halted, err_ovf, err_unf}), 0);
      startRun();

      $display("[TB] ADD exact sequence then underflow");
      opcode = 3'd0;
      for (int k = 0; k < 6; k++) begin
         checkOutput($sformatf("add_seq%0d", k),
                     int'({ir_write, mem_read, pc_inc, stack_pop, a_load, b_load, stack_push}),
                     int'(exp_seq[k]));
         if (k == 4) checkOutput("add_alu_op", int'(alu_op), 0);
         @(negedge clk);
      end
      checkOutput("add_depth", int'(depth), 1);
      checkOutput("add_refetch", int'(ir_write), 1);
      applyStimulus(3'd0, 1'b0);
      checkOutput("unf_halted", int'(halted), 1);
      checkOutput("unf_flag", int'(err_unf), 1);
      checkOutput("unf_no_pop", n_pop, 0);
      @(negedge clk);
      checkOutput("halt_absorbs", int'(halted), 1);

      $display("[TB] PUSH to overflow");
      doReset();
      startRun();
      for (int k = 0; k < 30; k++) applyStimulus(3'd4, 1'b0);
      checkOutput("push_full_depth", int'(depth), 32);
      applyStimulus(3'd4, 1'b0);
      checkOutput("ovf_flag", int'(err_ovf), 1);
      checkOutput("ovf_halted", int'(halted), 1);
      checkOutput("ovf_no_push", n_push, 0);
      checkOutput("ovf_depth", int'(depth), 32);

      $display("[TB] random opcode stream");
      doReset();
      startRun();
      for (int n = 0; n < 300; n++) begin
         rop = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) rop = 3'd4;
         checkModel(rop, 1'($urandom_range(0, 1)));
         if (halted) begin
            doReset();
            checkOutput("rand_reset_flags", int'({halted, err_ovf, err_unf}), 0);
            startRun();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
